// File: rtl/renkon_linebuf_pkg.sv
// Shared renkon constants for the line buffer plus a frame-size range check.
package renkon_linebuf_pkg;

  localparam int unsigned RnkDwidth = 16;
  localparam int unsigned RnkLwidth = 10;
  localparam int unsigned RnkMaxw   = 32;

  // Window edge length; also the smallest legal image edge.
  localparam int unsigned WinK = 5;

  function automatic logic size_ok(input int unsigned s, input int unsigned maxw);
    return (s >= WinK) && (s <= maxw);
  endfunction

endpackage

// File: rtl/renkon_linebuf_row.sv
// Single-row delay line: dout is the pixel pushed exactly `size` accepts earlier.
module renkon_linebuf_row
  import renkon_linebuf_pkg::*;
#(
  parameter int unsigned DWIDTH = RnkDwidth,
  parameter int unsigned LWIDTH = RnkLwidth,
  parameter int unsigned MAXW   = RnkMaxw
) (
  input  logic                     clk,
  input  logic                     xrst,
  input  logic                     clr,
  input  logic                     en,
  input  logic [LWIDTH-1:0]        size,
  input  logic signed [DWIDTH-1:0] din,
  output logic signed [DWIDTH-1:0] dout
);

  localparam int unsigned AW = $clog2(MAXW);

  logic signed [DWIDTH-1:0] mem [MAXW];
  logic [AW-1:0]            ptr_q, ptr_d;
  logic                     ptr_last;

  // Read-before-write at the same slot gives a delay of exactly `size` pushes.
  assign dout     = mem[ptr_q];
  assign ptr_last = (LWIDTH'(ptr_q) == size - LWIDTH'(1));

  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (en) begin
      ptr_d = ptr_last ? '0 : ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (xrst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      mem[ptr_q] <= din;
    end
  end

endmodule

// File: rtl/renkon_linebuf.sv
// Streaming 5x5 window generator: four row delay lines feed a 25-register window.
module renkon_linebuf
  import renkon_linebuf_pkg::*;
#(
  parameter int unsigned DWIDTH = RnkDwidth,
  parameter int unsigned LWIDTH = RnkLwidth,
  parameter int unsigned MAXW   = RnkMaxw
) (
  input  logic                     clk,
  input  logic                     xrst,
  input  logic                     buf_start,
  input  logic [LWIDTH-1:0]        img_size,
  input  logic                     in_en,
  input  logic signed [DWIDTH-1:0] pixel_in,
  output logic signed [DWIDTH-1:0] pixel_out0,
  output logic signed [DWIDTH-1:0] pixel_out1,
  output logic signed [DWIDTH-1:0] pixel_out2,
  output logic signed [DWIDTH-1:0] pixel_out3,
  output logic signed [DWIDTH-1:0] pixel_out4,
  output logic signed [DWIDTH-1:0] pixel_out5,
  output logic signed [DWIDTH-1:0] pixel_out6,
  output logic signed [DWIDTH-1:0] pixel_out7,
  output logic signed [DWIDTH-1:0] pixel_out8,
  output logic signed [DWIDTH-1:0] pixel_out9,
  output logic signed [DWIDTH-1:0] pixel_out10,
  output logic signed [DWIDTH-1:0] pixel_out11,
  output logic signed [DWIDTH-1:0] pixel_out12,
  output logic signed [DWIDTH-1:0] pixel_out13,
  output logic signed [DWIDTH-1:0] pixel_out14,
  output logic signed [DWIDTH-1:0] pixel_out15,
  output logic signed [DWIDTH-1:0] pixel_out16,
  output logic signed [DWIDTH-1:0] pixel_out17,
  output logic signed [DWIDTH-1:0] pixel_out18,
  output logic signed [DWIDTH-1:0] pixel_out19,
  output logic signed [DWIDTH-1:0] pixel_out20,
  output logic signed [DWIDTH-1:0] pixel_out21,
  output logic signed [DWIDTH-1:0] pixel_out22,
  output logic signed [DWIDTH-1:0] pixel_out23,
  output logic signed [DWIDTH-1:0] pixel_out24,
  output logic                     out_en,
  output logic                     busy,
  output logic                     done,
  output logic                     size_err
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e             state_q, state_d;
  logic [LWIDTH-1:0]  col_q, col_d;
  logic [LWIDTH-1:0]  row_q, row_d;
  logic [LWIDTH-1:0]  size_q, size_d;
  logic               out_en_q, out_en_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               start_row;
  logic               accept;
  logic               last_col;
  logic               last_row;

  logic signed [DWIDTH-1:0] win_q   [25];
  logic signed [DWIDTH-1:0] row_in  [4];
  logic signed [DWIDTH-1:0] row_out [4];

  assign accept   = (state_q == StRun) && in_en;
  assign last_col = (col_q == size_q - LWIDTH'(1));
  assign last_row = (row_q == size_q - LWIDTH'(1));

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    size_d    = size_q;
    out_en_d  = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    start_row = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (buf_start) begin
          if (size_ok(32'(img_size), MAXW)) begin
            state_d   = StRun;
            size_d    = img_size;
            col_d     = '0;
            row_d     = '0;
            start_row = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StRun: begin
        if (in_en) begin
          // A strobe needs four complete rows and four columns above/left of it.
          out_en_d = (row_q >= LWIDTH'(4)) && (col_q >= LWIDTH'(4));
          if (last_col) begin
            col_d = '0;
            row_d = row_q + LWIDTH'(1);
            if (last_row) begin
              state_d = StIdle;
              done_d  = 1'b1;
            end
          end else begin
            col_d = col_q + LWIDTH'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (xrst) begin
      state_q  <= StIdle;
      col_q    <= '0;
      row_q    <= '0;
      size_q   <= '0;
      out_en_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      row_q    <= row_d;
      size_q   <= size_d;
      out_en_q <= out_en_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign row_in[0] = pixel_in;

  for (genvar k = 0; k < 4; k++) begin : g_row
    if (k > 0) begin : g_chain
      assign row_in[k] = row_out[k-1];
    end
    renkon_linebuf_row #(
      .DWIDTH(DWIDTH),
      .LWIDTH(LWIDTH),
      .MAXW  (MAXW)
    ) u_row (
      .clk (clk),
      .xrst(xrst),
      .clr (start_row),
      .en  (accept),
      .size(size_q),
      .din (row_in[k]),
      .dout(row_out[k])
    );
  end

  // Window row 0 is the oldest image row, so it is fed by the deepest delay line.
  always_ff @(posedge clk) begin
    if (xrst) begin
      for (int k = 0; k < 25; k++) begin
        win_q[k] <= '0;
      end
    end else if (accept) begin
      for (int i = 0; i < 5; i++) begin
        for (int j = 0; j < 4; j++) begin
          win_q[5*i+j] <= win_q[5*i+j+1];
        end
      end
      for (int i = 0; i < 4; i++) begin
        win_q[5*i+4] <= row_out[3-i];
      end
      win_q[24] <= pixel_in;
    end
  end

  assign busy     = (state_q == StRun);
  assign out_en   = out_en_q;
  assign done     = done_q;
  assign size_err = err_q;

  assign pixel_out0  = win_q[0];
  assign pixel_out1  = win_q[1];
  assign pixel_out2  = win_q[2];
  assign pixel_out3  = win_q[3];
  assign pixel_out4  = win_q[4];
  assign pixel_out5  = win_q[5];
  assign pixel_out6  = win_q[6];
  assign pixel_out7  = win_q[7];
  assign pixel_out8  = win_q[8];
  assign pixel_out9  = win_q[9];
  assign pixel_out10 = win_q[10];
  assign pixel_out11 = win_q[11];
  assign pixel_out12 = win_q[12];
  assign pixel_out13 = win_q[13];
  assign pixel_out14 = win_q[14];
  assign pixel_out15 = win_q[15];
  assign pixel_out16 = win_q[16];
  assign pixel_out17 = win_q[17];
  assign pixel_out18 = win_q[18];
  assign pixel_out19 = win_q[19];
  assign pixel_out20 = win_q[20];
  assign pixel_out21 = win_q[21];
  assign pixel_out22 = win_q[22];
  assign pixel_out23 = win_q[23];
  assign pixel_out24 = win_q[24];

endmodule

// File: tb/tb_renkon_linebuf.sv
// Bench for renkon_linebuf: frame-level image model checked every cycle plus literal window checks.
module tb_renkon_linebuf;

  localparam int MAXW = 32;

  logic               clk = 1'b0;
  logic               xrst;
  logic               buf_start;
  logic [9:0]         img_size;
  logic               in_en;
  logic signed [15:0] pixel_in;
  logic signed [15:0] po [25];
  logic               out_en, busy, done, size_err;

  int nvec = 0;
  int nerr = 0;

  // Model state: frame image indexed linearly in raster order.
  int  m_img [MAXW*MAXW];
  bit  m_run = 0;
  int  m_size = 0;
  int  m_cnt = 0;
  bit  mv = 0;
  bit  exp_en, exp_done, exp_err, exp_zero;
  int  exp_win [25];

  // Windows seen on strobes, for literal checks.
  logic signed [15:0] cap [16][25];
  bit  cap_done [16];
  int  cap_n = 0;

  always #5 clk = ~clk;

  renkon_linebuf u_dut (
    .clk        (clk),
    .xrst       (xrst),
    .buf_start  (buf_start),
    .img_size   (img_size),
    .in_en      (in_en),
    .pixel_in   (pixel_in),
    .pixel_out0 (po[0]),
    .pixel_out1 (po[1]),
    .pixel_out2 (po[2]),
    .pixel_out3 (po[3]),
    .pixel_out4 (po[4]),
    .pixel_out5 (po[5]),
    .pixel_out6 (po[6]),
    .pixel_out7 (po[7]),
    .pixel_out8 (po[8]),
    .pixel_out9 (po[9]),
    .pixel_out10(po[10]),
    .pixel_out11(po[11]),
    .pixel_out12(po[12]),
    .pixel_out13(po[13]),
    .pixel_out14(po[14]),
    .pixel_out15(po[15]),
    .pixel_out16(po[16]),
    .pixel_out17(po[17]),
    .pixel_out18(po[18]),
    .pixel_out19(po[19]),
    .pixel_out20(po[20]),
    .pixel_out21(po[21]),
    .pixel_out22(po[22]),
    .pixel_out23(po[23]),
    .pixel_out24(po[24]),
    .out_en     (out_en),
    .busy       (busy),
    .done       (done),
    .size_err   (size_err)
  );

  task automatic chk(input string nm, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: what each edge must produce, from frame position arithmetic.
  initial forever begin
    int r, c;
    @(posedge clk);
    exp_en = 0; exp_done = 0; exp_err = 0; exp_zero = 0;
    if (xrst) begin
      m_run = 0; m_size = 0; m_cnt = 0; exp_zero = 1;
    end else if (!m_run && buf_start) begin
      if (img_size >= 5 && img_size <= 10'(MAXW)) begin
        m_run = 1; m_size = int'(img_size); m_cnt = 0;
      end else begin
        exp_err = 1;
      end
    end else if (m_run && in_en) begin
      m_img[m_cnt] = int'(pixel_in);
      r = m_cnt / m_size;
      c = m_cnt % m_size;
      if (r >= 4 && c >= 4) begin
        exp_en = 1;
        for (int i = 0; i < 5; i++)
          for (int j = 0; j < 5; j++)
            exp_win[5*i+j] = m_img[(r-4+i)*m_size + (c-4+j)];
      end
      m_cnt++;
      if (m_cnt == m_size*m_size) begin
        m_run = 0; exp_done = 1;
      end
    end
    mv = 1;
  end

  // Compare DUT outputs against the model on the inactive edge.
  initial forever begin
    @(negedge clk);
    if (mv) begin
      chk("out_en", 32'(out_en), 32'(exp_en));
      chk("done", 32'(done), 32'(exp_done));
      chk("busy", 32'(busy), 32'(m_run));
      chk("size_err", 32'(size_err), 32'(exp_err));
      if (exp_en)
        for (int k = 0; k < 25; k++) chk($sformatf("pix%0d", k), po[k], exp_win[k]);
      if (exp_zero)
        for (int k = 0; k < 25; k++) chk($sformatf("rst_pix%0d", k), po[k], 0);
      if (out_en === 1'b1 && cap_n < 16) begin
        for (int k = 0; k < 25; k++) cap[cap_n][k] = po[k];
        cap_done[cap_n] = done;
        cap_n++;
      end
    end
  end

  task automatic cyc(input bit rst, input bit bs, input int sz, input bit en, input int px);
    @(negedge clk);
    xrst = rst; buf_start = bs; img_size = 10'(sz); in_en = en; pixel_in = 16'(px);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask

  task automatic frame(input int sz, input int base, input bit gap, input int npix);
    cap_n = 0;
    cyc(0, 1, sz, 0, 0);
    for (int i = 0; i < npix; i++) begin
      if (gap) cyc(0, 0, 0, 0, 999);
      cyc(0, 0, 0, 1, base + i);
    end
  endtask

  task automatic check_6x6(input string tag, input int b);
    chk({tag, "_npulse"}, cap_n, 4);
    chk({tag, "_p1_out0"}, cap[0][0], b);
    chk({tag, "_p1_out4"}, cap[0][4], b + 4);
    chk({tag, "_p1_out20"}, cap[0][20], b + 24);
    chk({tag, "_p1_out24"}, cap[0][24], b + 28);
    chk({tag, "_p2_out0"}, cap[1][0], b + 1);
    chk({tag, "_p2_out24"}, cap[1][24], b + 29);
    chk({tag, "_p3_out0"}, cap[2][0], b + 6);
    chk({tag, "_p3_out24"}, cap[2][24], b + 34);
    chk({tag, "_done4"}, 32'(cap_done[3]), 1);
    chk({tag, "_done1"}, 32'(cap_done[0]), 0);
  endtask

  initial begin
    xrst = 1; buf_start = 0; img_size = 0; in_en = 0; pixel_in = 0;
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 6, 0, 0);  // reset beats a simultaneous start
    idle(2);

    frame(6, 0, 0, 36); idle(3);
    check_6x6("bb", 0);

    frame(5, -12, 0, 25); idle(3);
    chk("s5_npulse", cap_n, 1);
    chk("s5_out0", cap[0][0], -12);
    chk("s5_out12", cap[0][12], 0);
    chk("s5_out24", cap[0][24], 12);

    frame(6, 0, 1, 36); idle(3);
    check_6x6("gap", 0);

    cap_n = 0;
    cyc(0, 1, 4, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1, i);
    cyc(0, 1, MAXW + 1, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1, i);
    idle(2);
    chk("err_npulse", cap_n, 0);
    frame(6, 0, 0, 36); idle(3);
    check_6x6("after_err", 0);

    frame(6, 0, 0, 36); idle(1);
    frame(6, 100, 0, 36); idle(3);
    check_6x6("second", 100);

    // Start ignored mid-frame, then abort by reset after pixel 20.
    frame(6, 0, 0, 10);
    cyc(0, 1, 9, 1, 10);
    for (int i = 11; i <= 20; i++) cyc(0, 0, 0, 1, i);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 21);
    idle(3);
    frame(6, 0, 0, 36); idle(3);
    check_6x6("post_rst", 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
